branch_resolve_ctrl: RTL and testbench

//  Sequences ID-stage conditional-branch resolution for the pipelined MIPS core.

---
 rtl/cpu_branch_pkg.sv | 25 ++
 rtl/branch_cond_eval.sv | 30 +++
 rtl/branch_resolve_ctrl.sv | 145 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_branch_pkg.sv
// Shared branch-resolution definitions: br_type one-hot bit positions and FSM state encoding.
package cpu_branch_pkg;

   localparam int BR_TYPE_W = 6;

   localparam int BR_BEQ  = 0;
   localparam int BR_BNE  = 1;
   localparam int BR_BGEZ = 2;
   localparam int BR_BGTZ = 3;
   localparam int BR_BLEZ = 4;
   localparam int BR_BLTZ = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EVAL = 2'd2,
      ST_RESP = 2'd3
   } br_state_e;

   // Only the two-register compares depend on rt.
   function automatic logic br_needs_rt(input logic [BR_TYPE_W-1:0] t);
      return t[BR_BEQ] | t[BR_BNE];
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: one-hot type plus operands -> taken / illegal.
module branch_cond_eval
   import cpu_branch_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [BR_TYPE_W-1:0] br_type_i,
   input  logic [DATA_W-1:0]    rs_i,
   input  logic [DATA_W-1:0]    rt_i,
   output logic                 taken_o,
   output logic                 illegal_o
);

   logic rs_neg, rs_zero, eq;

   assign rs_neg    = rs_i[DATA_W-1];
   assign rs_zero   = (rs_i == '0);
   assign eq        = (rs_i == rt_i);
   assign illegal_o = !$onehot(br_type_i);

   // Illegal encodings never report taken, even if one matching bit would.
   assign taken_o = ~illegal_o & (
        (br_type_i[BR_BEQ]  &  eq)
      | (br_type_i[BR_BNE]  & ~eq)
      | (br_type_i[BR_BGEZ] & ~rs_neg)
      | (br_type_i[BR_BGTZ] & ~rs_neg & ~rs_zero)
      | (br_type_i[BR_BLEZ] & (rs_neg | rs_zero))
      | (br_type_i[BR_BLTZ] &  rs_neg));

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution sequencer: accept -> wait operands -> evaluate -> handshake result.
// Optional perf counters enabled by defining BRANCH_PERF_EN.
module branch_resolve_ctrl
   import cpu_branch_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
`ifdef BRANCH_PERF_EN
   ,parameter int CNT_W = 32
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 br_valid,
   output logic                 br_ready,
   input  logic [BR_TYPE_W-1:0] br_type,
   input  logic [PC_W-1:0]      br_pc4,
   input  logic [15:0]          br_imm,
   input  logic                 rs_ready,
   input  logic                 rt_ready,
   input  logic [DATA_W-1:0]    rs_val,
   input  logic [DATA_W-1:0]    rt_val,
   output logic                 busy,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_taken,
   output logic [PC_W-1:0]      res_target,
   output logic                 res_illegal
`ifdef BRANCH_PERF_EN
   ,output logic [CNT_W-1:0]    perf_br_cnt
   ,output logic [CNT_W-1:0]    perf_taken_cnt
   ,output logic [CNT_W-1:0]    perf_wait_cnt
`endif
);

   br_state_e             state_q, state_d;
   logic [BR_TYPE_W-1:0]  type_q;
   logic [PC_W-1:0]       pc4_q;
   logic [15:0]           imm_q;
   logic [DATA_W-1:0]     rs_q, rt_q;
   logic                  taken_q, illegal_q;
   logic [PC_W-1:0]       target_q, target_d;
   logic                  accept, opnd_go, consume, do_eval;
   logic                  eval_taken, eval_illegal;

   assign accept  = (state_q == ST_IDLE) & br_valid & ~flush;
   assign opnd_go = (state_q == ST_WAIT) & rs_ready & (rt_ready | ~br_needs_rt(type_q));
   assign do_eval = (state_q == ST_EVAL) & ~flush;
   assign consume = (state_q == ST_RESP) & res_ready & ~flush;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)    state_d = ST_WAIT;
         ST_WAIT: if (opnd_go)   state_d = ST_EVAL;
         ST_EVAL:                state_d = ST_RESP;
         ST_RESP: if (res_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         type_q <= '0;
         pc4_q  <= '0;
         imm_q  <= '0;
      end else if (accept) begin
         type_q <= br_type;
         pc4_q  <= br_pc4;
         imm_q  <= br_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_q <= '0;
         rt_q <= '0;
      end else if (opnd_go) begin
         rs_q <= rs_val;
         rt_q <= rt_val;
      end
   end

   branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
      .br_type_i (type_q),
      .rs_i      (rs_q),
      .rt_i      (rt_q),
      .taken_o   (eval_taken),
      .illegal_o (eval_illegal)
   );

   // Word offset: sign-extended imm shifted by two, wrapping modulo 2^PC_W.
   assign target_d = pc4_q + {{(PC_W-18){imm_q[15]}}, imm_q, 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
         target_q  <= '0;
      end else if (do_eval) begin
         taken_q   <= eval_taken;
         illegal_q <= eval_illegal;
         target_q  <= target_d;
      end
   end

   assign br_ready    = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign res_valid   = (state_q == ST_RESP);
   assign res_taken   = taken_q;
   assign res_target  = target_q;
   assign res_illegal = illegal_q;

`ifdef BRANCH_PERF_EN
   logic [CNT_W-1:0] br_cnt_q, taken_cnt_q, wait_cnt_q;

   // A flush in RESP drops the result, so it is not counted as consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         if (consume)              br_cnt_q    <= br_cnt_q + 1'b1;
         if (consume && taken_q)   taken_cnt_q <= taken_cnt_q + 1'b1;
         if (state_q == ST_WAIT)   wait_cnt_q  <= wait_cnt_q + 1'b1;
      end
   end

   assign perf_br_cnt    = br_cnt_q;
   assign perf_taken_cnt = taken_cnt_q;
   assign perf_wait_cnt  = wait_cnt_q;
`else
   logic unused_consume;
   assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized self-checking bench for branch_resolve_ctrl against a transaction-level model.
module tb_branch_resolve_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        br_valid = 1'b0;
   logic        br_ready;
   logic [5:0]  br_type = '0;
   logic [31:0] br_pc4 = '0;
   logic [15:0] br_imm = '0;
   logic        rs_ready = 1'b0, rt_ready = 1'b0;
   logic [31:0] rs_val = '0, rt_val = '0;
   logic        busy, res_valid, res_taken, res_illegal;
   logic        res_ready = 1'b0;
   logic [31:0] res_target;
`ifdef BRANCH_PERF_EN
   logic [31:0] perf_br_cnt, perf_taken_cnt, perf_wait_cnt;
`endif

   int total = 0, bad = 0;
   int exp_br = 0, exp_tk = 0, exp_wait = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .br_valid(br_valid), .br_ready(br_ready),
      .br_type(br_type), .br_pc4(br_pc4), .br_imm(br_imm), .rs_ready(rs_ready),
      .rt_ready(rt_ready), .rs_val(rs_val), .rt_val(rt_val), .busy(busy),
      .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
      .res_target(res_target), .res_illegal(res_illegal)
`ifdef BRANCH_PERF_EN
      ,.perf_br_cnt(perf_br_cnt), .perf_taken_cnt(perf_taken_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [5:0] t, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [31:0] pc4, input logic [15:0] imm,
                                 output logic tk, output logic il, output logic [31:0] tgt);
      int s, off;
      s   = int'($signed(rs));
      off = int'($signed(imm));
      il  = ($countones(t) != 1);
      tk  = 1'b0;
      if (!il)
         case (t)
            6'b000001: tk = (rs == rt);
            6'b000010: tk = (rs != rt);
            6'b000100: tk = (s >= 0);
            6'b001000: tk = (s > 0);
            6'b010000: tk = (s <= 0);
            6'b100000: tk = (s < 0);
            default:   tk = 1'b0;
         endcase
      tgt = pc4 + 32'(off * 4);
   endfunction

   task automatic chk_perf(input string tag);
`ifdef BRANCH_PERF_EN
      chk({tag, "_pbr"}, perf_br_cnt, exp_br);
      chk({tag, "_ptk"}, perf_taken_cnt, exp_tk);
      chk({tag, "_pwt"}, perf_wait_cnt, exp_wait);
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   // Offer a branch (entered and left at a negedge) and leave the DUT in WAIT.
   task automatic offer(input logic [5:0] t, input logic [31:0] pc4, input logic [15:0] imm);
      chk("idle_br_ready", br_ready, 1'b1);
      br_valid = 1'b1; br_type = t; br_pc4 = pc4; br_imm = imm;
      rs_ready = 1'b0; rt_ready = 1'b0; res_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      br_valid = 1'b0; br_type = 6'($urandom); br_pc4 = $urandom; br_imm = 16'($urandom);
      chk("acc_busy", busy, 1'b1);
      chk("acc_br_ready", br_ready, 1'b0);
   endtask

   task automatic run_br(input logic [5:0] t, input logic [31:0] pc4, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input int rsd, input int rtd, input int rdyd);
      logic tk, il;
      logic [31:0] tg;
      int w;
      model(t, rs, rt, pc4, imm, tk, il, tg);
      w = rsd;
      if ((t[0] | t[1]) && rtd > w) w = rtd;
      offer(t, pc4, imm);
      for (int k = 0; k <= w; k++) begin
         rs_ready = (k >= rsd);
         rt_ready = (k >= rtd);
         rs_val = (k == w) ? rs : $urandom;
         rt_val = (k == w) ? rt : $urandom;
         @(posedge clk); @(negedge clk);
         chk("pre_res_valid", res_valid, 1'b0);
         chk("pre_busy", busy, 1'b1);
      end
      exp_wait += w + 1;
      rs_ready = 1'b0; rt_ready = 1'b0; rs_val = $urandom; rt_val = $urandom;
      @(posedge clk); @(negedge clk);
      chk("res_valid", res_valid, 1'b1);
      chk("res_taken", res_taken, tk);
      chk("res_target", res_target, tg);
      chk("res_illegal", res_illegal, il);
      chk("resp_br_ready", br_ready, 1'b0);
      for (int j = 0; j < rdyd; j++) begin
         @(posedge clk); @(negedge clk);
         chk("hold_valid", res_valid, 1'b1);
         chk("hold_taken", res_taken, tk);
         chk("hold_target", res_target, tg);
      end
      res_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      res_ready = 1'b0;
      exp_br++;
      if (tk) exp_tk++;
      chk("done_valid", res_valid, 1'b0);
      chk("done_br_ready", br_ready, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk("done_target_held", res_target, tg);
      chk_perf("done");
   endtask

   // stage: 0 = flush in WAIT, 1 = in EVAL, 2 = in RESP (with res_ready high).
   task automatic flush_br(input int stage);
      offer(6'b000001, 32'h100, 16'h4);
      rs_ready = 1'b1; rt_ready = 1'b1;
      exp_wait += 1;
      if (stage >= 1) begin
         @(posedge clk); @(negedge clk);
         rs_ready = 1'b0; rt_ready = 1'b0;
      end
      if (stage >= 2) begin
         @(posedge clk); @(negedge clk);
         chk("fl_resp_valid", res_valid, 1'b1);
         res_ready = 1'b1;
      end
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0; res_ready = 1'b0; rs_ready = 1'b0; rt_ready = 1'b0;
      chk("fl_busy", busy, 1'b0);
      chk("fl_valid", res_valid, 1'b0);
      chk("fl_br_ready", br_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         chk("fl_no_pulse", res_valid, 1'b0);
      end
      chk_perf("flush");
   endtask

   initial begin
      logic [5:0] t;
      logic [31:0] rs, rt;
      #12;
      chk("rst_br_ready", br_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", res_valid, 1'b0);
      chk("rst_taken", res_taken, 1'b0);
      chk("rst_target", res_target, 32'h0);
      chk("rst_illegal", res_illegal, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk_perf("rst");

      run_br(6'b000001, 32'h3004, 16'hFFFF, 32'h1234, 32'h1234, 0, 0, 0);
      run_br(6'b000100, 32'h400, 16'h10, 32'h8000_0000, 32'h0, 0, 0, 0);
      run_br(6'b100000, 32'h400, 16'h10, 32'h8000_0000, 32'h0, 0, 0, 0);
      run_br(6'b010000, 32'h400, 16'h10, 32'h0, 32'h5, 0, 0, 0);
      run_br(6'b000010, 32'h800, 16'h8000, 32'h1, 32'h2, 0, 5, 0);
      run_br(6'b001000, 32'hFFFF_FFF0, 16'h7FFF, 32'h7, 32'h0, 1, 0, 4);
      run_br(6'b000011, 32'h2000, 16'h3, 32'h9, 32'h9, 0, 0, 0);
      run_br(6'b000000, 32'h2000, 16'h3, 32'h0, 32'h0, 2, 0, 1);

      flush_br(0);
      flush_br(1);
      flush_br(2);
      br_valid = 1'b1; flush = 1'b1; br_type = 6'b000001;
      @(posedge clk); @(negedge clk);
      br_valid = 1'b0; flush = 1'b0;
      chk("fl_idle_no_acc", busy, 1'b0);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 4) == 0) t = 6'($urandom);
         else                           t = 6'(1 << $urandom_range(0, 5));
         rt = $urandom;
         case ($urandom_range(0, 3))
            0: rs = $urandom;
            1: rs = 32'h0;
            2: rs = 32'h8000_0000;
            default: rs = rt;
         endcase
         run_br(t, $urandom & 32'hFFFF_FFFC, 16'($urandom), rs, rt,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Asynchronous reset while waiting on operands.
      run_br(6'b000001, 32'h5000, 16'h1, 32'h3, 32'h3, 0, 0, 0);
      offer(6'b000010, 32'h6000, 16'h2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_br_ready", br_ready, 1'b1);
      chk("arst_valid", res_valid, 1'b0);
      chk("arst_taken", res_taken, 1'b0);
      chk("arst_target", res_target, 32'h0);
      chk("arst_illegal", res_illegal, 1'b0);
      exp_br = 0; exp_tk = 0; exp_wait = 0;
      chk_perf("arst");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      run_br(6'b000100, 32'h7000, 16'hFFFE, 32'h1, 32'h0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
